// File: rtl/uart_peripheral.sv
// uart_peripheral
//   Memory-mapped 8N1 UART sitting behind the memory map decoder as Device 3.
//   One TX shift engine, one RX oversampling engine and five word registers:
//     0 TXDATA (R/W)  1 TXCTRL (W)  2 STATUS (R)  3 RXDATA (R)  4 RXCLR (W)
//
// Ports
//   clk      system clock, all state changes on the rising edge
//   rst      synchronous active-high reset
//   Select   chip select from the decoder
//   Write    write strobe from the decoder, qualified by Select
//   Addr     word offset from the decoder, bits [2:0] decoded
//   DataIn   write data from the decoder
//   DataOut  combinational read data back to the decoder
//   rx       asynchronous serial input
//   tx       serial output, idles high
module uart_peripheral #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Select,
   input  logic        Write,
   input  logic [31:0] Addr,
   input  logic [31:0] DataIn,
   output logic [31:0] DataOut,
   input  logic        rx,
   output logic        tx
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

   localparam logic [2:0] REG_TXDATA = 3'd0;
   localparam logic [2:0] REG_TXCTRL = 3'd1;
   localparam logic [2:0] REG_STATUS = 3'd2;
   localparam logic [2:0] REG_RXDATA = 3'd3;
   localparam logic [2:0] REG_RXCLR  = 3'd4;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   // Bus decode
   logic [2:0] reg_sel;
   logic       wr_en;
   logic       tx_start_cmd;
   logic       clr_ready;
   logic       clr_err;
   logic       unused_bits;

   assign reg_sel      = Addr[2:0];
   assign wr_en        = Select & Write;
   assign tx_start_cmd = wr_en && (reg_sel == REG_TXCTRL) && DataIn[0];
   assign clr_ready    = wr_en && (reg_sel == REG_RXCLR) && DataIn[0];
   assign clr_err      = wr_en && (reg_sel == REG_RXCLR) && DataIn[1];
   assign unused_bits  = ^{Addr[31:3], DataIn[31:8]};

   // TX state
   tx_state_t     tx_state, tx_state_next;
   logic [BW-1:0] tx_baud, tx_baud_next;
   logic [2:0]    tx_idx, tx_idx_next;
   logic [7:0]    tx_shift, tx_shift_next;
   logic [7:0]    tx_buffer;
   logic          tx_line, tx_line_next;
   logic          tx_busy;

   // RX state
   logic          rx_meta, rx_sync;
   rx_state_t     rx_state, rx_state_next;
   logic [BW-1:0] rx_baud, rx_baud_next;
   logic [2:0]    rx_idx, rx_idx_next;
   logic [7:0]    rx_shift, rx_shift_next;
   logic          rx_done_good;
   logic          rx_done_bad;
   logic [7:0]    rx_data;
   logic          rx_ready;
   logic          rx_overrun;
   logic          frame_err;

   assign tx_busy = (tx_state != TX_IDLE);
   assign tx      = tx_line;

   // TX buffer: a TXDATA write only ever touches the buffer, so a frame
   // already loaded into the shift register is never disturbed.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_buffer <= 8'h00;
      end else if (wr_en && (reg_sel == REG_TXDATA)) begin
         tx_buffer <= DataIn[7:0];
      end
   end

   // TX next-state logic. The serial line value is derived from the next
   // state so it can be registered: tx then falls in the cycle right after
   // the TXCTRL write edge and never glitches between bit periods.
   always_comb begin
      tx_state_next = tx_state;
      tx_baud_next  = tx_baud;
      tx_idx_next   = tx_idx;
      tx_shift_next = tx_shift;
      case (tx_state)
         TX_IDLE: begin
            if (tx_start_cmd) begin
               tx_state_next = TX_START;
               tx_baud_next  = '0;
               tx_idx_next   = 3'd0;
               tx_shift_next = tx_buffer;
            end
         end
         TX_START: begin
            if (tx_baud == BAUD_LAST) begin
               tx_state_next = TX_DATA;
               tx_baud_next  = '0;
               tx_idx_next   = 3'd0;
            end else begin
               tx_baud_next = tx_baud + BAUD_ONE;
            end
         end
         TX_DATA: begin
            if (tx_baud == BAUD_LAST) begin
               tx_baud_next  = '0;
               tx_shift_next = {1'b0, tx_shift[7:1]};
               if (tx_idx == 3'd7) begin
                  tx_state_next = TX_STOP;
               end else begin
                  tx_idx_next = tx_idx + 3'd1;
               end
            end else begin
               tx_baud_next = tx_baud + BAUD_ONE;
            end
         end
         TX_STOP: begin
            if (tx_baud == BAUD_LAST) begin
               tx_state_next = TX_IDLE;
               tx_baud_next  = '0;
            end else begin
               tx_baud_next = tx_baud + BAUD_ONE;
            end
         end
         default: begin
            tx_state_next = TX_IDLE;
            tx_baud_next  = '0;
         end
      endcase

      case (tx_state_next)
         TX_START: tx_line_next = 1'b0;
         TX_DATA:  tx_line_next = tx_shift_next[0];
         default:  tx_line_next = 1'b1;
      endcase
   end

   // TX state register. Reset abandons any frame and drives the line high
   // on the following cycle without finishing a stop bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_baud  <= '0;
         tx_idx   <= 3'd0;
         tx_shift <= 8'h00;
         tx_line  <= 1'b1;
      end else begin
         tx_state <= tx_state_next;
         tx_baud  <= tx_baud_next;
         tx_idx   <= tx_idx_next;
         tx_shift <= tx_shift_next;
         tx_line  <= tx_line_next;
      end
   end

   // Two-flop synchronizer for the asynchronous rx pin. It resets to the
   // idle (high) level so leaving reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   // RX next-state logic. The start bit is re-checked half a bit after the
   // falling edge; every later sample is one full bit further on, which
   // places the data and stop samples near the middle of each bit.
   always_comb begin
      rx_state_next = rx_state;
      rx_baud_next  = rx_baud;
      rx_idx_next   = rx_idx;
      rx_shift_next = rx_shift;
      rx_done_good  = 1'b0;
      rx_done_bad   = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (!rx_sync) begin
               rx_state_next = RX_START;
               rx_baud_next  = '0;
            end
         end
         RX_START: begin
            if (rx_baud == HALF_LAST) begin
               rx_baud_next = '0;
               rx_idx_next  = 3'd0;
               if (rx_sync) begin
                  rx_state_next = RX_IDLE;
               end else begin
                  rx_state_next = RX_DATA;
               end
            end else begin
               rx_baud_next = rx_baud + BAUD_ONE;
            end
         end
         RX_DATA: begin
            if (rx_baud == BAUD_LAST) begin
               rx_baud_next  = '0;
               rx_shift_next = {rx_sync, rx_shift[7:1]};
               if (rx_idx == 3'd7) begin
                  rx_state_next = RX_STOP;
               end else begin
                  rx_idx_next = rx_idx + 3'd1;
               end
            end else begin
               rx_baud_next = rx_baud + BAUD_ONE;
            end
         end
         RX_STOP: begin
            if (rx_baud == BAUD_LAST) begin
               rx_state_next = RX_IDLE;
               rx_baud_next  = '0;
               rx_done_good  = rx_sync;
               rx_done_bad   = ~rx_sync;
            end else begin
               rx_baud_next = rx_baud + BAUD_ONE;
            end
         end
         default: begin
            rx_state_next = RX_IDLE;
            rx_baud_next  = '0;
         end
      endcase
   end

   // RX state register
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state <= RX_IDLE;
         rx_baud  <= '0;
         rx_idx   <= 3'd0;
         rx_shift <= 8'h00;
      end else begin
         rx_state <= rx_state_next;
         rx_baud  <= rx_baud_next;
         rx_idx   <= rx_idx_next;
         rx_shift <= rx_shift_next;
      end
   end

   // Receive flags. Clears are applied first and frame completion second,
   // so a completion in the same cycle as an RXCLR write wins. Overrun looks
   // at rx_ready as it was before this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data    <= 8'h00;
         rx_ready   <= 1'b0;
         rx_overrun <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         if (clr_ready) begin
            rx_ready <= 1'b0;
         end
         if (clr_err) begin
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
         end
         if (rx_done_good) begin
            rx_data  <= rx_shift;
            rx_ready <= 1'b1;
            if (rx_ready) begin
               rx_overrun <= 1'b1;
            end
         end
         if (rx_done_bad) begin
            frame_err <= 1'b1;
         end
      end
   end

   // Read mux: write-only and out-of-range offsets read as zero
   always_comb begin
      DataOut = 32'h0;
      if (Select) begin
         case (reg_sel)
            REG_TXDATA: DataOut = {24'h0, tx_buffer};
            REG_STATUS: DataOut = {28'h0, frame_err, rx_overrun, rx_ready, tx_busy};
            REG_RXDATA: DataOut = {24'h0, rx_data};
            default:    DataOut = 32'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_peripheral.sv
// tb_uart_peripheral
//   Self-checking bench for uart_peripheral with CLKS_PER_BIT=4. A small
//   behavioural model of the register file (TX buffer, RX byte and flags)
//   supplies every expected value; serial frames are built as 10-bit
//   {stop, data, start} vectors and compared bit period by bit period.
module tb_uart_peripheral;

   localparam int CPB = 4;

   logic        clk;
   logic        rst;
   logic        Select;
   logic        Write;
   logic [31:0] Addr;
   logic [31:0] DataIn;
   logic [31:0] DataOut;
   logic        rx;
   logic        tx;

   int numChecks = 0;
   int numFails  = 0;

   // Reference model state
   logic [7:0] m_txbuf;
   logic [7:0] m_rxdata;
   logic       m_ready;
   logic       m_overrun;
   logic       m_ferr;

   uart_peripheral #(.CLKS_PER_BIT(CPB)) dut (
      .clk     (clk),
      .rst     (rst),
      .Select  (Select),
      .Write   (Write),
      .Addr    (Addr),
      .DataIn  (DataIn),
      .DataOut (DataOut),
      .rx      (rx),
      .tx      (tx)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with its expected value
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      numChecks++;
      if (observed !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Expected STATUS with the TX engine idle
   function automatic logic [31:0] expStatus();
      return {28'h0, m_ferr, m_overrun, m_ready, 1'b0};
   endfunction

   // Register write across one rising edge; call and return on a falling edge
   task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d);
      Select = 1'b1;
      Write  = 1'b1;
      Addr   = {29'h0, a};
      DataIn = d;
      @(negedge clk);
      Select = 1'b0;
      Write  = 1'b0;
      Addr   = 32'h0;
      DataIn = 32'h0;
   endtask

   // Zero-cycle read inside the low clock phase
   task automatic busRead(input logic sel, input logic [31:0] a, output logic [31:0] d);
      Select = sel;
      Write  = 1'b0;
      Addr   = a;
      #1;
      d = DataOut;
      Select = 1'b0;
   endtask

   // Apply an RXCLR write to the model
   task automatic modelClear(input logic [1:0] c);
      if (c[0]) m_ready = 1'b0;
      if (c[1]) begin
         m_overrun = 1'b0;
         m_ferr    = 1'b0;
      end
   endtask

   // Apply a completed received frame to the model
   task automatic modelRxFrame(input logic [7:0] b, input logic stopBit);
      if (stopBit) begin
         if (m_ready) m_overrun = 1'b1;
         m_ready  = 1'b1;
         m_rxdata = b;
      end else begin
         m_ferr = 1'b1;
      end
   endtask

   // Send one byte out of TX and compare the line every cycle. An optional
   // register write (midAddr/midData) is slipped in at cycle midCycle.
   task automatic runTxFrame(input logic [7:0] b, input int midCycle,
                             input logic [2:0] midAddr, input logic [31:0] midData);
      logic [9:0]  frame;
      logic [31:0] d;
      applyStimulus(3'd0, {24'h0, b});
      m_txbuf = b;
      applyStimulus(3'd1, 32'h1);
      frame = {1'b1, b, 1'b0};
      for (int i = 0; i < 10 * CPB; i++) begin
         checkOutput("tx_bit", {31'h0, tx}, {31'h0, frame[i / CPB]});
         if (i == 0 || i == 10 * CPB - 1) begin
            busRead(1'b1, 32'd2, d);
            checkOutput("tx_busy_set", d, expStatus() | 32'h1);
         end
         if (i == midCycle) begin
            Select = 1'b1;
            Write  = 1'b1;
            Addr   = {29'h0, midAddr};
            DataIn = midData;
            if (midAddr == 3'd0) m_txbuf = midData[7:0];
         end
         @(negedge clk);
         Select = 1'b0;
         Write  = 1'b0;
      end
      for (int i = 0; i < 3 * CPB; i++) begin
         checkOutput("tx_idle", {31'h0, tx}, 32'h1);
         if (i == 0) begin
            busRead(1'b1, 32'd2, d);
            checkOutput("tx_busy_clr", d, expStatus());
         end
         @(negedge clk);
      end
      busRead(1'b1, 32'd0, d);
      checkOutput("txdata_read", d, {24'h0, m_txbuf});
   endtask

   // Drive one 8N1 frame on rx while polling STATUS each cycle; readyCycle
   // returns the first cycle rx_ready was seen high (-1 if never). At
   // clrCycle an RXCLR 0x1 write replaces the poll.
   task automatic runRxFrame(input logic [7:0] b, input logic stopBit,
                             input int clrCycle, output int readyCycle);
      logic [9:0] frame;
      frame = {stopBit, b, 1'b0};
      readyCycle = -1;
      for (int i = 0; i < 10 * CPB + 6; i++) begin
         rx = (i < 10 * CPB) ? frame[i / CPB] : 1'b1;
         if (i == clrCycle) begin
            Select = 1'b1;
            Write  = 1'b1;
            Addr   = 32'd4;
            DataIn = 32'h1;
         end else begin
            Select = 1'b1;
            Write  = 1'b0;
            Addr   = 32'd2;
            #1;
            if (readyCycle < 0 && DataOut[1]) readyCycle = i;
            Select = 1'b0;
         end
         @(negedge clk);
         Select = 1'b0;
         Write  = 1'b0;
      end
   endtask

   // Read STATUS and RXDATA and compare both with the model
   task automatic checkRxRegs(input string tagS, input string tagD);
      logic [31:0] d;
      busRead(1'b1, 32'd2, d);
      checkOutput(tagS, d, expStatus());
      busRead(1'b1, 32'd3, d);
      checkOutput(tagD, d, {24'h0, m_rxdata});
   endtask

   // Main sequence
   initial begin
      logic [31:0] d;
      logic [7:0]  b;
      logic        stopBit;
      logic [1:0]  c;
      int          rc;
      int          cal;

      rst = 1'b1; Select = 1'b0; Write = 1'b0; Addr = 32'h0; DataIn = 32'h0; rx = 1'b1;
      m_txbuf = 8'h00; m_rxdata = 8'h00; m_ready = 1'b0; m_overrun = 1'b0; m_ferr = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      checkOutput("reset_tx", {31'h0, tx}, 32'h1);
      busRead(1'b1, 32'd2, d);
      checkOutput("reset_status", d, 32'h0);
      busRead(1'b1, 32'd0, d);
      checkOutput("reset_txdata", d, 32'h0);
      busRead(1'b1, 32'd3, d);
      checkOutput("reset_rxdata", d, 32'h0);

      // Directed TX: 0xA5 with a second TXCTRL start mid-frame
      $display("[TB] TX directed 0xA5");
      runTxFrame(8'hA5, 10, 3'd1, 32'h1);

      // Random TX frames with a TXDATA overwrite in flight
      $display("[TB] TX random frames");
      for (int k = 0; k < 4; k++) begin
         b = 8'($urandom);
         runTxFrame(b, int'($urandom_range(37, 2)), 3'd0, $urandom);
      end

      // Directed RX 0x3C, also calibrates completion latency
      $display("[TB] RX directed 0x3C");
      runRxFrame(8'h3C, 1'b1, -1, cal);
      modelRxFrame(8'h3C, 1'b1);
      checkRxRegs("rx3c_status", "rx3c_data");
      checkOutput("rx_latency_ok", {31'h0, (cal >= 39 && cal <= 42)}, 32'h1);
      applyStimulus(3'd4, 32'h1);
      modelClear(2'b01);
      checkRxRegs("rxclr_status", "rxclr_data");

      // Overrun then frame error
      $display("[TB] RX overrun and frame error");
      runRxFrame(8'h11, 1'b1, -1, rc);
      modelRxFrame(8'h11, 1'b1);
      runRxFrame(8'h22, 1'b1, -1, rc);
      modelRxFrame(8'h22, 1'b1);
      checkRxRegs("overrun_status", "overrun_data");
      runRxFrame(8'h5A, 1'b0, -1, rc);
      modelRxFrame(8'h5A, 1'b0);
      checkRxRegs("ferr_status", "ferr_data");
      applyStimulus(3'd4, 32'h2);
      modelClear(2'b10);
      checkRxRegs("errclr_status", "errclr_data");

      // One-cycle low glitch on rx
      $display("[TB] RX glitch");
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      checkRxRegs("glitch_status", "glitch_data");

      // RXCLR landing on the completion edge while rx_ready is already set:
      // the set must win, and the old ready flag makes it an overrun
      $display("[TB] RX set-wins");
      b = 8'($urandom);
      runRxFrame(b, 1'b1, cal - 1, rc);
      modelRxFrame(b, 1'b1);
      checkRxRegs("setwins_status", "setwins_data");
      applyStimulus(3'd4, 32'h3);
      modelClear(2'b11);

      // Random RX frames with random clears
      $display("[TB] RX random frames");
      for (int k = 0; k < 6; k++) begin
         b = 8'($urandom);
         stopBit = ($urandom_range(3, 0) != 0);
         runRxFrame(b, stopBit, -1, rc);
         modelRxFrame(b, stopBit);
         checkRxRegs("rxrand_status", "rxrand_data");
         c = 2'($urandom);
         applyStimulus(3'd4, {30'h0, c});
         modelClear(c);
         checkRxRegs("rxrand_clr_status", "rxrand_clr_data");
      end

      // Address decode
      $display("[TB] Decode");
      applyStimulus(3'd0, 32'h1234_56C3);
      m_txbuf = 8'hC3;
      busRead(1'b1, 32'd0, d);
      checkOutput("dec_txdata", d, 32'hC3);
      busRead(1'b0, 32'd0, d);
      checkOutput("dec_nosel_txdata", d, 32'h0);
      busRead(1'b0, 32'd3, d);
      checkOutput("dec_nosel_rxdata", d, 32'h0);
      for (int a = 5; a < 8; a++) begin
         busRead(1'b1, 32'(a), d);
         checkOutput("dec_out_of_range", d, 32'h0);
      end
      busRead(1'b1, 32'd1, d);
      checkOutput("dec_txctrl_wo", d, 32'h0);
      busRead(1'b1, 32'd4, d);
      checkOutput("dec_rxclr_wo", d, 32'h0);
      applyStimulus(3'd2, 32'hFFFF_FFFF);
      applyStimulus(3'd3, 32'hFFFF_FFFF);
      checkRxRegs("dec_ro_status", "dec_ro_rxdata");

      // Reset in the middle of a TX frame
      $display("[TB] Reset mid-frame");
      applyStimulus(3'd0, 32'h00);
      applyStimulus(3'd1, 32'h1);
      repeat (8) @(negedge clk);
      checkOutput("midframe_tx_low", {31'h0, tx}, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midreset_tx", {31'h0, tx}, 32'h1);
      busRead(1'b1, 32'd2, d);
      checkOutput("midreset_status", d, 32'h0);
      busRead(1'b1, 32'd0, d);
      checkOutput("midreset_txdata", d, 32'h0);
      busRead(1'b1, 32'd3, d);
      checkOutput("midreset_rxdata", d, 32'h0);
      rst = 1'b0;
      repeat (2 * CPB) @(negedge clk);
      checkOutput("postreset_tx", {31'h0, tx}, 32'h1);
      busRead(1'b1, 32'd2, d);
      checkOutput("postreset_status", d, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
